// File: rtl/lse_reduce_ctrl.sv
// Sequencer for a streaming log-sum-exp reduction: feeds one element at a time
// to an external LSE adder and returns the reduced value per vector.
module lse_reduce_ctrl #(
    parameter  int unsigned WIDTH   = 24,
    parameter  int unsigned MAX_LEN = 256,
    localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             add_enable,
    output logic [WIDTH-1:0] add_operand_a,
    output logic [WIDTH-1:0] add_operand_b,
    input  logic [WIDTH-1:0] add_result,
    input  logic             add_valid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_trunc,
    output logic             busy
);

    localparam logic [WIDTH-1:0] NEG_INF_VAL = {1'b1, {(WIDTH - 1){1'b0}}};
    localparam logic [CNT_W-1:0] MAX_CNT     = CNT_W'(MAX_LEN);
    localparam logic             SINGLE_LEN  = (MAX_LEN == 32'd1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACCUM = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] acc, acc_d;
    logic [WIDTH-1:0] elem, elem_d;
    logic [CNT_W-1:0] count, count_d;
    logic             last_q, last_d;
    logic             trunc_q, trunc_d;
    logic [CNT_W-1:0] count_inc;
    logic             take;

    // Next-state and datapath update; outputs are registered from these values
    always_comb begin
        state_d   = state;
        acc_d     = acc;
        elem_d    = elem;
        count_d   = count;
        last_d    = last_q;
        trunc_d   = trunc_q;
        count_inc = count + CNT_W'(1);
        take      = in_valid && in_ready;
        case (state)
            IDLE: begin
                if (take) begin
                    acc_d   = in_data;
                    count_d = CNT_W'(1);
                    last_d  = in_last || SINGLE_LEN;
                    trunc_d = !in_last && SINGLE_LEN;
                    state_d = last_d ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (take) begin
                    elem_d  = in_data;
                    count_d = count_inc;
                    last_d  = in_last || (count_inc == MAX_CNT);
                    trunc_d = !in_last && (count_inc == MAX_CNT);
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (add_valid) begin
                    acc_d   = add_result;
                    state_d = last_q ? DONE : ACCUM;
                end
            end
            DONE: begin
                if (out_ready) begin
                    acc_d   = NEG_INF_VAL;
                    count_d = '0;
                    last_d  = 1'b0;
                    trunc_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            acc           <= NEG_INF_VAL;
            elem          <= '0;
            count         <= '0;
            last_q        <= 1'b0;
            trunc_q       <= 1'b0;
            in_ready      <= 1'b0;
            add_enable    <= 1'b0;
            add_operand_a <= '0;
            add_operand_b <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_count     <= '0;
            out_trunc     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state      <= state_d;
            acc        <= acc_d;
            elem       <= elem_d;
            count      <= count_d;
            last_q     <= last_d;
            trunc_q    <= trunc_d;
            in_ready   <= (state_d == IDLE) || (state_d == ACCUM);
            add_enable <= (state_d == ISSUE);
            // Operands are captured on entry to ISSUE and held until the next issue
            if (state_d == ISSUE) begin
                add_operand_a <= acc_d;
                add_operand_b <= elem_d;
            end
            out_valid  <= (state_d == DONE);
            out_data   <= (state_d == DONE) ? acc_d : '0;
            out_count  <= (state_d == DONE) ? count_d : '0;
            out_trunc  <= (state_d == DONE) && trunc_d;
            busy       <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_lse_reduce_ctrl.sv
// Directed bench for lse_reduce_ctrl with a one-cycle max(a,b)+3 adder model.
module tb_lse_reduce_ctrl;

    localparam int unsigned W      = 24;
    localparam int unsigned ML     = 4;
    localparam int unsigned CW     = $clog2(ML + 1);
    localparam int unsigned TMO    = 50;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          add_enable;
    logic [W-1:0]  add_operand_a;
    logic [W-1:0]  add_operand_b;
    logic [W-1:0]  add_result;
    logic          add_valid;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] out_count;
    logic          out_trunc;
    logic          busy;

    logic          mdl_en;
    logic          mdl_valid = 1'b0;
    logic [W-1:0]  mdl_result = '0;
    logic          inj_valid;
    logic [W-1:0]  inj_result;
    int            en_cnt = 0;
    int            en_base;
    int            errors = 0;
    int            checks = 0;

    always #5 clk = ~clk;

    lse_reduce_ctrl #(.WIDTH(W), .MAX_LEN(ML)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .add_enable    (add_enable),
        .add_operand_a (add_operand_a),
        .add_operand_b (add_operand_b),
        .add_result    (add_result),
        .add_valid     (add_valid),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_count     (out_count),
        .out_trunc     (out_trunc),
        .busy          (busy)
    );

    // One-cycle adder returning max(a,b)+3, plus an injection path
    always @(posedge clk) begin
        mdl_valid  <= mdl_en && add_enable;
        mdl_result <= ((add_operand_a > add_operand_b) ? add_operand_a : add_operand_b) + W'(3);
    end
    assign add_valid  = mdl_valid || inj_valid;
    assign add_result = inj_valid ? inj_result : mdl_result;

    always @(negedge clk) if (add_enable === 1'b1) en_cnt = en_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [W-1:0] d, input logic l);
        bit ok = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("send_ready_timeout", 32'(ok), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out(input string tag, input logic [W-1:0] d, input int unsigned c,
                            input logic t);
        bit ok = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            if (out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_valid"}, 32'(ok), 32'd1);
        check({tag, "_data"},  32'(out_data), 32'(d));
        check({tag, "_count"}, 32'(out_count), c);
        check({tag, "_trunc"}, 32'(out_trunc), 32'(t));
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_released"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        out_ready = 1'b0; mdl_en = 1'b1; inj_valid = 1'b0; inj_result = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready",  32'(in_ready), 32'd0);
        check("rst_add_en",    32'(add_enable), 32'd0);
        check("rst_op_a",      32'(add_operand_a), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_busy",      32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single element vector: no adder issue
        en_base = en_cnt;
        send(24'h000100, 1'b1);
        wait_out("single", 24'h000100, 1, 1'b0);
        check("single_no_issue", 32'(en_cnt - en_base), 32'd0);
        release_out("single");

        // Three element vector with throughput timing
        en_base = en_cnt;
        send(24'h000100, 1'b0);
        send(24'h000200, 1'b0);
        check("tp_issue_en",   32'(add_enable), 32'd1);
        check("tp_issue_rdy",  32'(in_ready), 32'd0);
        check("tp_issue_op_a", 32'(add_operand_a), 32'h100);
        check("tp_issue_op_b", 32'(add_operand_b), 32'h200);
        @(negedge clk);
        check("tp_wait_en",  32'(add_enable), 32'd0);
        check("tp_wait_rdy", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("tp_accum_rdy", 32'(in_ready), 32'd1);
        send(24'h000050, 1'b1);
        wait_out("vec3", 24'h000206, 3, 1'b0);
        check("vec3_issues", 32'(en_cnt - en_base), 32'd2);

        // Backpressure: result held while out_ready is low
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data",  32'(out_data), 32'h206);
            check("hold_count", 32'(out_count), 32'd3);
            check("hold_rdy",   32'(in_ready), 32'd0);
        end
        release_out("vec3");
        check("vec3_idle_rdy", 32'(in_ready), 32'd1);

        // First element at negative infinity passes through unchanged
        send(24'h800000, 1'b1);
        wait_out("neginf", 24'h800000, 1, 1'b0);
        release_out("neginf");

        // Truncation at MAX_LEN=4, then a fresh vector from element 5
        send(24'h000010, 1'b0);
        send(24'h000020, 1'b0);
        send(24'h000030, 1'b0);
        send(24'h000040, 1'b0);
        wait_out("trunc", 24'h000043, 4, 1'b1);
        release_out("trunc");
        send(24'h000050, 1'b0);
        send(24'h000060, 1'b1);
        wait_out("after_trunc", 24'h000063, 2, 1'b0);
        release_out("after_trunc");

        // Spurious add_valid while accumulating is ignored
        send(24'h000100, 1'b0);
        inj_valid = 1'b1; inj_result = 24'h000ABC;
        @(negedge clk);
        inj_valid = 1'b0;
        check("inj_busy", 32'(busy), 32'd1);
        check("inj_rdy",  32'(in_ready), 32'd1);
        send(24'h000080, 1'b1);
        wait_out("inj", 24'h000103, 2, 1'b0);
        release_out("inj");

        // Reset during WAIT, then a stale add_valid
        mdl_en = 1'b0;
        send(24'h000100, 1'b0);
        send(24'h000200, 1'b1);
        check("rw_issue", 32'(add_enable), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rw_rdy",      32'(in_ready), 32'd0);
        check("rw_busy",     32'(busy), 32'd0);
        check("rw_out_vld",  32'(out_valid), 32'd0);
        check("rw_out_data", 32'(out_data), 32'd0);
        inj_valid = 1'b1; inj_result = 24'h000777;
        @(negedge clk);
        inj_valid = 1'b0;
        check("rw_stale_rdy",  32'(in_ready), 32'd1);
        check("rw_stale_busy", 32'(busy), 32'd0);
        check("rw_stale_vld",  32'(out_valid), 32'd0);
        mdl_en = 1'b1;
        send(24'h000300, 1'b0);
        send(24'h000100, 1'b1);
        wait_out("rw_new", 24'h000303, 2, 1'b0);
        release_out("rw_new");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
